shop_dispatcher: RTL and testbench

//   Scheduler between N_Q customer queues ({num[7:4],type[3:0]} entries) and N_SRV service counters.

---
 rtl/shop_dispatcher.sv | 159 +++++++++++++++
 tb/tb_shop_dispatcher.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shop_dispatcher.sv
// shop_dispatcher: pops customers from N_Q queues into N_SRV service counters and counts down their service time.
// Build option: define DISPATCH_PRIO_EN for fixed lowest-index queue priority; default is round-robin.
module shop_dispatcher #(
    parameter int N_Q   = 3,
    parameter int N_SRV = 2,
    parameter int QI_W  = (N_Q > 1) ? $clog2(N_Q) : 1,
    parameter int SI_W  = (N_SRV > 1) ? $clog2(N_SRV) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [N_Q-1:0]       q_empty,
    input  logic [4*N_Q-1:0]     q_qn,
    input  logic [4*N_Q-1:0]     q_qt,
    output logic [N_Q-1:0]       q_re,
    output logic [N_SRV-1:0]     srv_busy,
    output logic [4*N_SRV-1:0]   srv_num,
    output logic [4*N_SRV-1:0]   srv_left,
    output logic [N_SRV-1:0]     srv_done,
    output logic                 disp_valid,
    output logic [QI_W-1:0]      disp_q,
    output logic [SI_W-1:0]      disp_srv
);
    typedef enum logic {S_SCAN, S_POP} state_t;
    state_t                  state_q, state_d;
    logic [QI_W-1:0]         win_q_q, win_q_d, rr_ptr_q, rr_ptr_d;
    logic [SI_W-1:0]         win_s_q, win_s_d;
    logic [QI_W-1:0]         arb_lo, arb_hi, arb_idx;
    logic                    hi_found;
    logic [SI_W-1:0]         idle_idx;
    logic                    any_idle;
    logic [N_Q-1:0][3:0]     qn_a, qt_a;
    logic [N_SRV-1:0]        busy_q, done_q;
    logic [N_SRV-1:0][3:0]   num_q, left_q;
    logic                    dv_q;
    logic [QI_W-1:0]         dq_q;
    logic [SI_W-1:0]         ds_q;
    logic                    pop;
    logic [3:0]              head_len;

    assign qn_a = q_qn;
    assign qt_a = q_qt;

    // Search from rr_ptr upward first, then wrap to the lowest non-empty queue; rr_ptr stuck at 0 gives fixed priority.
    always_comb begin
        arb_lo   = '0;
        arb_hi   = '0;
        hi_found = 1'b0;
        for (int k = N_Q - 1; k >= 0; k--) begin
            if (!q_empty[k]) begin
                arb_lo = QI_W'(k);
                if (k >= int'(rr_ptr_q)) begin
                    arb_hi   = QI_W'(k);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign arb_idx = hi_found ? arb_hi : arb_lo;

    // Lowest-index idle counter, judged on the registered busy flags.
    always_comb begin
        idle_idx = '0;
        any_idle = 1'b0;
        for (int s = N_SRV - 1; s >= 0; s--) begin
            if (!busy_q[s]) begin
                idle_idx = SI_W'(s);
                any_idle = 1'b1;
            end
        end
    end

    // Next state: latch the winners in SCAN, always spend exactly one cycle in POP.
    always_comb begin
        state_d = state_q;
        win_q_d = win_q_q;
        win_s_d = win_s_q;
        if (state_q == S_SCAN) begin
            if (any_idle && !(&q_empty)) begin
                state_d = S_POP;
                win_q_d = arb_idx;
                win_s_d = idle_idx;
            end
        end else begin
            state_d = S_SCAN;
        end
    end

    // The pop is abandoned if the chosen queue drained between SCAN and POP.
    assign pop      = (state_q == S_POP) && !q_empty[win_q_q];
    assign q_re     = (rst_n && pop) ? (N_Q'(1) << win_q_q) : '0;
    assign head_len = (qt_a[win_q_q] == 4'd0) ? 4'd1 : qt_a[win_q_q];
`ifdef DISPATCH_PRIO_EN
    assign rr_ptr_d = '0;
`else
    assign rr_ptr_d = pop ? ((win_q_q == QI_W'(N_Q - 1)) ? '0 : win_q_q + 1'b1) : rr_ptr_q;
`endif

    // FSM and arbitration state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_SCAN;
            win_q_q  <= '0;
            win_s_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q_q  <= win_q_d;
            win_s_q  <= win_s_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Per-counter load on dispatch, otherwise count down on tick; done pulses the cycle after the last tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            done_q <= '0;
            num_q  <= '0;
            left_q <= '0;
        end else begin
            for (int s = 0; s < N_SRV; s++) begin
                done_q[s] <= tick && busy_q[s] && (left_q[s] == 4'd1);
                if (pop && (win_s_q == SI_W'(s))) begin
                    busy_q[s] <= 1'b1;
                    num_q[s]  <= qn_a[win_q_q];
                    left_q[s] <= head_len;
                end else if (tick && busy_q[s]) begin
                    left_q[s] <= left_q[s] - 4'd1;
                    if (left_q[s] == 4'd1) busy_q[s] <= 1'b0;
                end
            end
        end
    end

    // Dispatch report: one-cycle valid, indices held until the next dispatch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dv_q <= 1'b0;
            dq_q <= '0;
            ds_q <= '0;
        end else begin
            dv_q <= pop;
            if (pop) begin
                dq_q <= win_q_q;
                ds_q <= win_s_q;
            end
        end
    end

    assign srv_busy   = busy_q;
    assign srv_done   = done_q;
    assign srv_num    = num_q;
    assign srv_left   = left_q;
    assign disp_valid = dv_q;
    assign disp_q     = dq_q;
    assign disp_srv   = ds_q;
endmodule

// File: tb/tb_shop_dispatcher.sv
// tb_shop_dispatcher: directed and randomized checks of shop_dispatcher against a queue-level reference model.
module tb_shop_dispatcher;
    localparam int N_Q   = 3;
    localparam int N_SRV = 2;
    localparam int QI_W  = 2;
    localparam int SI_W  = 1;
`ifdef DISPATCH_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n, tick;
    logic [N_Q-1:0]       q_empty, q_re;
    logic [4*N_Q-1:0]     q_qn, q_qt;
    logic [N_SRV-1:0]     srv_busy, srv_done;
    logic [4*N_SRV-1:0]   srv_num, srv_left;
    logic                 disp_valid;
    logic [QI_W-1:0]      disp_q;
    logic [SI_W-1:0]      disp_srv;

    always #5 clk = ~clk;

    shop_dispatcher #(.N_Q(N_Q), .N_SRV(N_SRV)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .q_empty(q_empty), .q_qn(q_qn), .q_qt(q_qt),
        .q_re(q_re), .srv_busy(srv_busy), .srv_num(srv_num), .srv_left(srv_left), .srv_done(srv_done),
        .disp_valid(disp_valid), .disp_q(disp_q), .disp_srv(disp_srv)
    );

    logic [7:0]     qd [N_Q][$];
    logic [N_Q-1:0] hide;
    int             n_checks = 0;
    int             n_fail = 0;

    bit             m_pend;
    int             m_pq, m_ps, m_rr, m_dq, m_ds;
    bit             m_dv;
    bit             m_busy [N_SRV];
    bit             m_done [N_SRV];
    int             m_num [N_SRV];
    int             m_left [N_SRV];
    logic [N_Q-1:0] exp_re;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N_Q; k++) begin
            q_empty[k] = (qd[k].size() == 0) || hide[k];
            q_qn[4*k +: 4] = (qd[k].size() != 0) ? qd[k][0][7:4] : 4'd0;
            q_qt[4*k +: 4] = (qd[k].size() != 0) ? qd[k][0][3:0] : 4'd0;
        end
    endtask

    task automatic model_clear();
        m_pend = 0; m_pq = 0; m_ps = 0; m_rr = 0; m_dv = 0; m_dq = 0; m_ds = 0;
        for (int s = 0; s < N_SRV; s++) begin
            m_busy[s] = 0; m_done[s] = 0; m_num[s] = 0; m_left[s] = 0;
        end
    endtask

    // A decision taken in one cycle is committed in the next if the queue is still non-empty.
    task automatic model_step();
        bit pop, fq, fs;
        int pq, ps, base;
        exp_re = '0;
        if (!rst_n) begin
            model_clear();
            return;
        end
        pop = m_pend && !q_empty[m_pq];
        if (pop) exp_re[m_pq] = 1'b1;
        fq = 0; fs = 0; pq = 0; ps = 0;
        for (int s = 0; s < N_SRV; s++)
            if (!fs && !m_busy[s]) begin fs = 1; ps = s; end
        base = PRIO ? 0 : m_rr;
        for (int i = 0; i < N_Q; i++) begin
            int k = (base + i) % N_Q;
            if (!fq && !q_empty[k]) begin fq = 1; pq = k; end
        end
        for (int s = 0; s < N_SRV; s++) begin
            m_done[s] = tick && m_busy[s] && (m_left[s] == 1);
            if (tick && m_busy[s]) begin
                m_left[s] = m_left[s] - 1;
                if (m_left[s] == 0) m_busy[s] = 0;
            end
        end
        m_dv = pop;
        if (pop) begin
            m_busy[m_ps] = 1;
            m_num[m_ps]  = int'(q_qn[4*m_pq +: 4]);
            m_left[m_ps] = (q_qt[4*m_pq +: 4] == 4'd0) ? 1 : int'(q_qt[4*m_pq +: 4]);
            m_dq = m_pq;
            m_ds = m_ps;
            if (!PRIO) m_rr = (m_pq + 1) % N_Q;
        end
        if (!m_pend && fs && fq) begin
            m_pend = 1; m_pq = pq; m_ps = ps;
        end else begin
            m_pend = 0;
        end
    endtask

    task automatic check_regs();
        logic [N_SRV-1:0]   eb, ed;
        logic [4*N_SRV-1:0] en, el;
        for (int s = 0; s < N_SRV; s++) begin
            eb[s] = m_busy[s];
            ed[s] = m_done[s];
            en[4*s +: 4] = 4'(m_num[s]);
            el[4*s +: 4] = 4'(m_left[s]);
        end
        chk("srv_busy", 16'(srv_busy), 16'(eb));
        chk("srv_done", 16'(srv_done), 16'(ed));
        chk("srv_num", 16'(srv_num), 16'(en));
        chk("srv_left", 16'(srv_left), 16'(el));
        chk("disp_valid", 16'(disp_valid), 16'(m_dv));
        chk("disp_q", 16'(disp_q), 16'(m_dq));
        chk("disp_srv", 16'(disp_srv), 16'(m_ds));
    endtask

    task automatic cycle(input logic t);
        logic [N_Q-1:0] re_s;
        tick = t;
        drive_inputs();
        #3;
        model_step();
        chk("q_re", 16'(q_re), 16'(exp_re));
        re_s = q_re;
        @(posedge clk);
        #1;
        for (int k = 0; k < N_Q; k++)
            if (re_s[k] && qd[k].size() != 0) void'(qd[k].pop_front());
        hide = '0;
        tick = 1'b0;
        check_regs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N_Q; k++) qd[k].delete();
        cycle(1'b0);
        rst_n = 1'b1;
    endtask

    task automatic push(input int k, input int n, input int t);
        qd[k].push_back({4'(n), 4'(t)});
    endtask

    initial begin
        model_clear();
        hide = '0;
        tick = 1'b0;
        rst_n = 1'b0;
        // Reset held three cycles with every queue non-empty.
        for (int k = 0; k < N_Q; k++) push(k, k + 1, 2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            chk("rst_re", 16'(q_re), 16'h0);
            chk("rst_busy", 16'(srv_busy), 16'h0);
            chk("rst_dv", 16'(disp_valid), 16'h0);
        end
        for (int k = 0; k < N_Q; k++) qd[k].delete();
        rst_n = 1'b1;
        // Single dispatch from q0, then three ticks to completion.
        push(0, 5, 3);
        cycle(1'b0);
        cycle(1'b0);
        chk("t2_dv", 16'(disp_valid), 16'h1);
        chk("t2_num", 16'(srv_num[3:0]), 16'h5);
        chk("t2_left", 16'(srv_left[3:0]), 16'h3);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk("t2_busy", 16'(srv_busy[0]), 16'h0);
        chk("t2_done", 16'(srv_done[0]), 16'h1);
        cycle(1'b0);
        chk("t2_done_once", 16'(srv_done[0]), 16'h0);
        // Round-robin over three full queues with two counters.
        do_reset();
        for (int k = 0; k < N_Q; k++) begin
            push(k, 2*k + 1, 15);
            push(k, 2*k + 2, 15);
        end
        cycle(1'b0); cycle(1'b0);
        chk("t3_q_a", 16'(disp_q), 16'h0);
        chk("t3_s_a", 16'(disp_srv), 16'h0);
        cycle(1'b0); cycle(1'b0);
        chk("t3_q_b", 16'(disp_q), PRIO ? 16'h0 : 16'h1);
        chk("t3_s_b", 16'(disp_srv), 16'h1);
        for (int i = 0; i < 15; i++) cycle(1'b1);
        cycle(1'b0); cycle(1'b0);
        chk("t3_q_c", 16'(disp_q), PRIO ? 16'h1 : 16'h2);
        chk("t3_s_c", 16'(disp_srv), 16'h0);
        cycle(1'b0); cycle(1'b0);
        chk("t3_q_d", 16'(disp_q), PRIO ? 16'h1 : 16'h0);
        // Zero service length becomes one tick.
        do_reset();
        push(1, 7, 0);
        cycle(1'b0); cycle(1'b0);
        chk("t4_num", 16'(srv_num[3:0]), 16'h7);
        chk("t4_left", 16'(srv_left[3:0]), 16'h1);
        cycle(1'b1);
        chk("t4_busy", 16'(srv_busy[0]), 16'h0);
        chk("t4_done", 16'(srv_done[0]), 16'h1);
        // Saturation: both counters busy, counter 1 frees first.
        do_reset();
        push(0, 1, 15); push(0, 2, 2); push(0, 3, 4);
        for (int i = 0; i < 6; i++) cycle(1'b0);
        chk("t5_sat_re", 16'(q_re), 16'h0);
        cycle(1'b1); cycle(1'b1);
        chk("t5_busy", 16'(srv_busy), 16'h1);
        cycle(1'b0); cycle(1'b0);
        chk("t5_dv", 16'(disp_valid), 16'h1);
        chk("t5_srv", 16'(disp_srv), 16'h1);
        // Queue empties during the pop cycle.
        do_reset();
        push(2, 9, 4);
        cycle(1'b0);
        hide[2] = 1'b1;
        cycle(1'b0);
        chk("t6_dv", 16'(disp_valid), 16'h0);
        chk("t6_busy", 16'(srv_busy), 16'h0);
        cycle(1'b0); cycle(1'b0);
        chk("t6_dv2", 16'(disp_valid), 16'h1);
        chk("t6_q", 16'(disp_q), 16'h2);
        // Random traffic, ticks, queue glitches and occasional reset.
        for (int i = 0; i < 600; i++) begin
            int k = $urandom_range(0, N_Q - 1);
            if ($urandom_range(0, 2) == 0 && qd[k].size() < 4)
                push(k, $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) hide[$urandom_range(0, N_Q - 1)] = 1'b1;
            rst_n = ($urandom_range(0, 79) != 0);
            cycle(logic'($urandom_range(0, 1)));
        end
        rst_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
